// File: rtl/atm_pager_quad.sv
// ATM-style memory pager covering all four 16 KB Z80 windows with NMAP selectable map sets,
// DOS-entry detection with a configurable Z80 clock stall, and registered page-register readback.
module atm_pager_quad #(
    parameter int         NMAP      = 2,
    parameter int         DOS_MAP   = 1,
    parameter logic [5:0] DOS_AHI   = 6'h3D,
    parameter int         STALL_CYC = 3,
    localparam int        MW        = (NMAP > 1) ? $clog2(NMAP) : 1
) (
    input  logic          fclk,
    input  logic          rst_n,
    input  logic          zpos,
    input  logic          zneg,
    input  logic [15:0]   za,
    input  logic [7:0]    zd,
    input  logic          mreq_n,
    input  logic          m1_n,
    input  logic          pager_off,
    input  logic [MW-1:0] map_sel,
    input  logic [5:0]    pent1m_page,
    input  logic          pent1m_ram0_0,
    input  logic          pent1m_1m_on,
    input  logic          dos,
    input  logic          atmF7_wr,
    input  logic          rb_stb,
    output logic [7:0]    page,
    output logic          romnram,
    output logic [7:0]    rb_data,
    output logic          dos_turn_on,
    output logic          dos_turn_off,
    output logic          zclk_stall
);

    logic [7:0] pg  [4][NMAP];
    logic       ram [4][NMAP];
    logic       d7  [4][NMAP];

    logic [3:0] cnt;
    logic       m1_n_reg;
    logic       mreq_n_reg;

    logic [1:0] win;
    logic [7:0] cur_pg;
    logic       cur_ram;
    logic       cur_d7;
    logic [7:0] page_nxt;
    logic       rom_nxt;
    logic       fetch;
    logic       unused_za;

    assign win       = za[15:14];
    assign cur_pg    = pg[win][map_sel];
    assign cur_ram   = ram[win][map_sel];
    assign cur_d7    = d7[win][map_sel];
    assign unused_za = ^za[7:0];

    // RAM pages with d7 set take their low bits from the 7FFD page register.
    function automatic logic [7:0] merge_7ffd(input logic [7:0] base, input logic [5:0] p7ffd,
                                              input logic on_1m);
        return on_1m ? {base[7:6], p7ffd} : {base[7:3], p7ffd[2:0]};
    endfunction

    always_comb begin
        page_nxt = 8'hFF;
        rom_nxt  = 1'b1;
        if (pager_off) begin
            page_nxt = 8'hFF;
            rom_nxt  = 1'b1;
        end else if (pent1m_ram0_0 && (win == 2'd0)) begin
            page_nxt = 8'h00;
            rom_nxt  = 1'b0;
        end else begin
            rom_nxt = ~cur_ram;
            if (!cur_d7)
                page_nxt = cur_pg;
            else if (cur_ram)
                page_nxt = merge_7ffd(cur_pg, pent1m_page, pent1m_1m_on);
            else
                page_nxt = {cur_pg[7:1], dos};
        end
    end

    // Opcode fetch: first falling Z80 edge with MREQ low during an M1 cycle.
    assign fetch        = zneg & ~m1_n_reg & ~mreq_n & mreq_n_reg;
    assign dos_turn_on  = fetch & (za[13:8] == DOS_AHI) & (win == 2'd0)
                        & (map_sel == MW'(DOS_MAP)) & d7[0][DOS_MAP] & ~ram[0][DOS_MAP];
    assign dos_turn_off = fetch & cur_ram;
    assign zclk_stall   = dos_turn_on | (cnt != 4'd0);

    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            for (int m = 0; m < NMAP; m++) begin
                pg[0][m]  <= (m == 0) ? 8'hFE : 8'hFC;
                ram[0][m] <= 1'b0;
                d7[0][m]  <= 1'b1;
                pg[1][m]  <= 8'h05;
                ram[1][m] <= 1'b1;
                d7[1][m]  <= 1'b0;
                pg[2][m]  <= 8'h02;
                ram[2][m] <= 1'b1;
                d7[2][m]  <= 1'b0;
                pg[3][m]  <= 8'h00;
                ram[3][m] <= 1'b1;
                d7[3][m]  <= 1'b1;
            end
            cnt        <= 4'd0;
            m1_n_reg   <= 1'b1;
            mreq_n_reg <= 1'b1;
            page       <= 8'hFF;
            romnram    <= 1'b1;
            rb_data    <= 8'h00;
        end else begin
            if (atmF7_wr) begin
                if (za[11]) begin
                    pg[win][map_sel]  <= ~{2'b00, zd[5:0]};
                    ram[win][map_sel] <= zd[6];
                    d7[win][map_sel]  <= zd[7];
                end else begin
                    pg[win][map_sel]  <= ~zd;
                    ram[win][map_sel] <= 1'b1;
                end
            end

            if (zpos)
                m1_n_reg <= m1_n;
            if (zneg)
                mreq_n_reg <= mreq_n;

            if (dos_turn_on)
                cnt <= 4'(STALL_CYC);
            else if (cnt != 4'd0)
                cnt <= cnt - 4'd1;

            page    <= page_nxt;
            romnram <= rom_nxt;
            if (rb_stb)
                rb_data <= {cur_d7, cur_ram, ~cur_pg[5:0]};
        end
    end

endmodule

// File: tb/tb_atm_pager_quad.sv
// Bench for atm_pager_quad: vector table for lookups/writes/readback through a scoreboard queue,
// plus hand-written sequences for DOS entry/exit strobes, the clock stall and reset mid-stall.
module tb_atm_pager_quad;

    logic        fclk = 1'b0;
    logic        rst_n;
    logic        zpos, zneg;
    logic [15:0] za;
    logic [7:0]  zd;
    logic        mreq_n, m1_n;
    logic        pager_off;
    logic [0:0]  map_sel;
    logic [5:0]  pent1m_page;
    logic        pent1m_ram0_0, pent1m_1m_on;
    logic        dos, atmF7_wr, rb_stb;
    logic [7:0]  page;
    logic        romnram;
    logic [7:0]  rb_data;
    logic        dos_turn_on, dos_turn_off, zclk_stall;

    atm_pager_quad dut (
        .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .zneg(zneg), .za(za), .zd(zd),
        .mreq_n(mreq_n), .m1_n(m1_n), .pager_off(pager_off), .map_sel(map_sel),
        .pent1m_page(pent1m_page), .pent1m_ram0_0(pent1m_ram0_0), .pent1m_1m_on(pent1m_1m_on),
        .dos(dos), .atmF7_wr(atmF7_wr), .rb_stb(rb_stb), .page(page), .romnram(romnram),
        .rb_data(rb_data), .dos_turn_on(dos_turn_on), .dos_turn_off(dos_turn_off),
        .zclk_stall(zclk_stall)
    );

    always #5 fclk = ~fclk;

    typedef struct {
        logic [15:0] za;
        logic [7:0]  zd;
        logic        wr;
        logic        ms;
        logic [5:0]  pp;
        logic        on1m;
        logic        r00;
        logic        off;
        logic        dos;
        logic        rb;
        logic [7:0]  exp_page;
        logic        exp_rom;
        logic [7:0]  exp_rb;
    } vec_t;

    typedef struct {
        logic [7:0] page;
        logic       rom;
        logic [7:0] rb;
        int         idx;
    } exp_t;

    vec_t vecs[23];
    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;

    function automatic vec_t mkv(logic [15:0] a, logic [7:0] d, logic w, logic ms, logic [5:0] pp,
                                 logic on1m, logic r00, logic off, logic ds, logic rb,
                                 logic [7:0] ep, logic er, logic [7:0] erb);
        vec_t v;
        v.za = a; v.zd = d; v.wr = w; v.ms = ms; v.pp = pp; v.on1m = on1m; v.r00 = r00;
        v.off = off; v.dos = ds; v.rb = rb; v.exp_page = ep; v.exp_rom = er; v.exp_rb = erb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    endtask

    task automatic apply(input int i);
        vec_t v;
        exp_t e;
        v = vecs[i];
        za = v.za; zd = v.zd; atmF7_wr = v.wr; map_sel = v.ms; pent1m_page = v.pp;
        pent1m_1m_on = v.on1m; pent1m_ram0_0 = v.r00; pager_off = v.off; dos = v.dos;
        rb_stb = v.rb; zpos = 1'b0; zneg = 1'b0;
        sbq.push_back('{v.exp_page, v.exp_rom, v.exp_rb, i});
        @(posedge fclk); #1;
        if (sbq.size() == 0) begin
            checks++;
            $display("FAIL vec%0d_queue: got empty, expected entry", i);
        end else begin
            e = sbq.pop_front();
            chk($sformatf("vec%0d_page", e.idx), page, e.page);
            chk($sformatf("vec%0d_romnram", e.idx), {7'd0, romnram}, {7'd0, e.rom});
            chk($sformatf("vec%0d_rb_data", e.idx), rb_data, e.rb);
        end
        atmF7_wr = 1'b0; rb_stb = 1'b0;
    endtask

    task automatic zstep(input string name, input logic zp, input logic zn, input logic m1,
                         input logic mq, input logic eon, input logic eoff, input logic est);
        zpos = zp; zneg = zn; m1_n = m1; mreq_n = mq;
        #1;
        chk({name, "_on"}, {7'd0, dos_turn_on}, {7'd0, eon});
        chk({name, "_off"}, {7'd0, dos_turn_off}, {7'd0, eoff});
        chk({name, "_stall"}, {7'd0, zclk_stall}, {7'd0, est});
        @(posedge fclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mkv(16'h0000, 8'h00, 0, 0, 6'h00, 0, 0, 0, 0, 0, 8'hFE, 1, 8'h00);
        vecs[1]  = mkv(16'h0000, 8'h00, 0, 1, 6'h00, 0, 0, 0, 0, 0, 8'hFC, 1, 8'h00);
        vecs[2]  = mkv(16'h4000, 8'h00, 0, 1, 6'h00, 0, 0, 0, 0, 0, 8'h05, 0, 8'h00);
        vecs[3]  = mkv(16'h8000, 8'h00, 0, 0, 6'h00, 0, 0, 0, 0, 0, 8'h02, 0, 8'h00);
        vecs[4]  = mkv(16'hC000, 8'h00, 0, 0, 6'h15, 1, 0, 0, 0, 0, 8'h15, 0, 8'h00);
        vecs[5]  = mkv(16'h0000, 8'h00, 0, 0, 6'h00, 0, 0, 0, 1, 0, 8'hFF, 1, 8'h00);
        vecs[6]  = mkv(16'hBFF7, 8'hC3, 1, 0, 6'h00, 0, 0, 0, 0, 0, 8'h02, 0, 8'h00);
        vecs[7]  = mkv(16'hBFF7, 8'h00, 0, 0, 6'h2A, 1, 0, 0, 0, 0, 8'hEA, 0, 8'h00);
        vecs[8]  = mkv(16'hBFF7, 8'h00, 0, 0, 6'h2A, 0, 0, 0, 0, 0, 8'hFA, 0, 8'h00);
        vecs[9]  = mkv(16'hBFF7, 8'h00, 0, 0, 6'h2A, 0, 0, 0, 0, 1, 8'hFA, 0, 8'hC3);
        vecs[10] = mkv(16'hBFF7, 8'h00, 0, 1, 6'h00, 0, 0, 0, 0, 0, 8'h02, 0, 8'hC3);
        vecs[11] = mkv(16'h37F7, 8'h10, 1, 0, 6'h00, 0, 0, 0, 0, 0, 8'hFE, 1, 8'hC3);
        vecs[12] = mkv(16'h37F7, 8'h00, 0, 0, 6'h2F, 1, 0, 0, 0, 0, 8'hEF, 0, 8'hC3);
        vecs[13] = mkv(16'h37F7, 8'h00, 0, 0, 6'h2F, 1, 0, 1, 0, 0, 8'hFF, 1, 8'hC3);
        vecs[14] = mkv(16'h37F7, 8'h00, 0, 0, 6'h2F, 1, 1, 0, 0, 0, 8'h00, 0, 8'hC3);
        vecs[15] = mkv(16'h37F7, 8'h00, 0, 0, 6'h2F, 1, 1, 1, 0, 0, 8'hFF, 1, 8'hC3);
        vecs[16] = mkv(16'h4000, 8'h00, 0, 1, 6'h00, 0, 1, 0, 0, 0, 8'h05, 0, 8'hC3);
        vecs[17] = mkv(16'h4800, 8'h85, 1, 0, 6'h00, 0, 0, 0, 0, 1, 8'h05, 0, 8'h7A);
        vecs[18] = mkv(16'h4800, 8'h00, 0, 0, 6'h00, 0, 0, 0, 0, 1, 8'hFA, 1, 8'h85);
        vecs[19] = mkv(16'h4800, 8'h00, 0, 0, 6'h00, 0, 0, 0, 1, 0, 8'hFB, 1, 8'h85);
        vecs[20] = mkv(16'hBFF7, 8'h00, 0, 0, 6'h00, 0, 0, 0, 0, 0, 8'h02, 0, 8'h00);
        vecs[21] = mkv(16'h37F7, 8'h00, 0, 0, 6'h00, 0, 0, 0, 0, 0, 8'hFE, 1, 8'h00);
        vecs[22] = mkv(16'h4800, 8'h00, 0, 0, 6'h00, 0, 0, 0, 0, 1, 8'h05, 0, 8'h7A);

        rst_n = 1'b0; zpos = 1'b0; zneg = 1'b0; za = 16'h0000; zd = 8'h00;
        mreq_n = 1'b1; m1_n = 1'b1; pager_off = 1'b0; map_sel = 1'b0; pent1m_page = 6'h00;
        pent1m_ram0_0 = 1'b0; pent1m_1m_on = 1'b0; dos = 1'b0; atmF7_wr = 1'b0; rb_stb = 1'b0;
        repeat (2) @(posedge fclk);
        #1;
        chk("reset_page", page, 8'hFF);
        chk("reset_romnram", {7'd0, romnram}, 8'h01);
        chk("reset_rb_data", rb_data, 8'h00);
        chk("reset_stall", {7'd0, zclk_stall}, 8'h00);
        chk("reset_on", {7'd0, dos_turn_on}, 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i <= 19; i++) apply(i);

        za = 16'h3D2F; map_sel = 1'b1; pager_off = 1'b0; pent1m_ram0_0 = 1'b0; dos = 1'b0;
        zstep("prep", 1, 1, 1, 1, 0, 0, 0);
        zstep("m1", 1, 0, 0, 1, 0, 0, 0);
        zstep("fetch1", 0, 1, 0, 0, 1, 0, 1);
        zstep("stall1a", 0, 0, 0, 0, 0, 0, 1);
        zstep("stall1b", 0, 0, 0, 0, 0, 0, 1);
        zstep("stall1c", 0, 0, 0, 0, 0, 0, 1);
        zstep("stall1end", 0, 0, 0, 0, 0, 0, 0);
        zstep("mreq_hi2", 0, 1, 0, 1, 0, 0, 0);
        zstep("fetch2", 0, 1, 0, 0, 1, 0, 1);
        zstep("stall2a", 0, 0, 0, 0, 0, 0, 1);
        zstep("mreq_hi3", 0, 1, 0, 1, 0, 0, 1);
        zstep("fetch3", 0, 1, 0, 0, 1, 0, 1);
        zstep("stall3a", 0, 0, 0, 0, 0, 0, 1);
        zstep("stall3b", 0, 0, 0, 0, 0, 0, 1);
        zstep("stall3c", 0, 0, 0, 0, 0, 0, 1);
        zstep("stall3end", 0, 0, 0, 0, 0, 0, 0);

        map_sel = 1'b0;
        zstep("mreq_hi4", 0, 1, 0, 1, 0, 0, 0);
        zstep("fetch_map0", 0, 1, 0, 0, 0, 1, 0);
        za = 16'h8000; map_sel = 1'b1;
        zstep("mreq_hi5", 0, 1, 0, 1, 0, 0, 0);
        zstep("fetch_ram", 0, 1, 0, 0, 0, 1, 0);
        za = 16'h0100;
        zstep("mreq_hi6", 0, 1, 0, 1, 0, 0, 0);
        zstep("fetch_rom", 0, 1, 0, 0, 0, 0, 0);
        za = 16'h3D00;
        zstep("m1_hi", 1, 0, 1, 1, 0, 0, 0);
        zstep("mreq_hi7", 0, 1, 1, 1, 0, 0, 0);
        zstep("fetch_no_m1", 0, 1, 1, 0, 0, 0, 0);

        za = 16'h3D2F;
        zstep("rm1", 1, 0, 0, 0, 0, 0, 0);
        zstep("rmreq_hi", 0, 1, 0, 1, 0, 0, 0);
        zstep("rfetch", 0, 1, 0, 0, 1, 0, 1);
        rst_n = 1'b0;
        zstep("rst_edge", 0, 0, 0, 0, 0, 0, 1);
        chk("rst_mid_stall", {7'd0, zclk_stall}, 8'h00);
        chk("rst_mid_page", page, 8'hFF);
        chk("rst_mid_romnram", {7'd0, romnram}, 8'h01);
        chk("rst_mid_rb_data", rb_data, 8'h00);
        rst_n = 1'b1; m1_n = 1'b1; mreq_n = 1'b1;

        for (int i = 20; i <= 22; i++) apply(i);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
